uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_receiver.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Parity support is selected by UART_RECEIVER_PARITY_EN.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Flops reset high so an idle line shows no edge after reset.
module uart_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic s0_q;
    logic s1_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else begin
            s0_q <= d_i;
            s1_q <= s0_q;
        end
    end

    assign q_o = s1_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 by default, 8E1 with UART_RECEIVER_PARITY_EN.
// Bytes are delivered on a valid/ready output with overrun detection.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ  = 27_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              overrun,
    output logic              frame_error,
    output logic              parity_error
);

    localparam int CPB = CLOCK_HZ / BAUD_RATE;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CPB - 1);

    uart_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              bad_q, bad_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovr_q, ovr_d;
    logic              fe_q, fe_d;
    logic              rx_prev_q;
    logic              rx_s;
    logic              tick;
    logic              done;

    uart_sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (uart_rx),
        .q_o   (rx_s)
    );

`ifdef UART_RECEIVER_PARITY_EN
    logic pe_q, pe_d;
`endif

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        bad_d   = bad_q;
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = 1'b0;
        fe_d    = 1'b0;
        done    = 1'b0;
`ifdef UART_RECEIVER_PARITY_EN
        pe_d    = 1'b0;
`endif
        if (valid_q && out_ready) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = START;
                    cnt_d   = HALF;
                    bad_d   = 1'b0;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s) begin
                    state_d = DATA;
                    cnt_d   = FULL;
                    idx_d   = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    cnt_d   = FULL;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RECEIVER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (rx_s != ^shift_q) bad_d = 1'b1;
                    cnt_d   = FULL;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
`ifdef UART_RECEIVER_PARITY_EN
                    pe_d = bad_q;
`endif
                    if (rx_s) begin
                        state_d = IDLE;
                        done    = !bad_q;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A pending byte can be replaced only if it is taken this cycle.
        if (done) begin
            if (!valid_q || out_ready) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            bad_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            bad_q     <= bad_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            ovr_q     <= ovr_d;
            fe_q      <= fe_d;
            rx_prev_q <= rx_s;
        end
    end

`ifdef UART_RECEIVER_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) pe_q <= 1'b0;
        else       pe_q <= pe_d;
    end
    assign parity_error = pe_q;
`else
    assign parity_error = 1'b0;
`endif

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign overrun     = ovr_q;
    assign frame_error = fe_q;

endmodule
